// File: rtl/rtc_12h_ctrl.sv
// 12-hour real-time clock with a run/hold/load controller.
// Time advances on seconds strobes; a validated load can be applied from HOLD.
module rtc_12h_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       hold,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_h12,
    input  logic [5:0] ld_min,
    input  logic       ld_ap,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [3:0] h12,
    output logic       ap,
    output logic [4:0] h24,
    output logic       ld_err,
    output logic       hour_pulse
);

    typedef enum logic [1:0] {RUN, HOLD, LOAD} state_t;

    state_t     state;
    logic [3:0] cap_h12;
    logic [5:0] cap_min;
    logic       cap_ap;

    logic [5:0] sec_inc;
    logic [5:0] min_inc;
    logic [3:0] h12_inc;
    logic       ap_inc;
    logic       hour_wrap;
    logic       load_ok;

    function automatic logic [4:0] to_h24(input logic [3:0] h, input logic pm);
        logic [4:0] base;
        base = (h == 4'd12) ? 5'd0 : {1'b0, h};
        return pm ? base + 5'd12 : base;
    endfunction

    // Time one second ahead of the current registers.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sec_inc   = sec + 6'd1;
        min_inc   = min;
        h12_inc   = h12;
        ap_inc    = ap;
        hour_wrap = 1'b0;
        if (sec == 6'd59) begin
            sec_inc = 6'd0;
            if (min == 6'd59) begin
                min_inc   = 6'd0;
                hour_wrap = 1'b1;
                if (h12 == 4'd11) begin
                    h12_inc = 4'd12;
                    ap_inc  = ~ap;
                end else if (h12 == 4'd12) begin
                    h12_inc = 4'd1;
                end else begin
                    h12_inc = h12 + 4'd1;
                end
            end else begin
                min_inc = min + 6'd1;
            end
        end
    end

    assign load_ok  = (cap_h12 >= 4'd1) && (cap_h12 <= 4'd12) && (cap_min <= 6'd59);
    assign ld_ready = (state == HOLD);

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            sec        <= 6'd0;
            min        <= 6'd0;
            h12        <= 4'd12;
            ap         <= 1'b0;
            h24        <= 5'd0;
            ld_err     <= 1'b0;
            hour_pulse <= 1'b0;
            cap_h12    <= 4'd12;
            cap_min    <= 6'd0;
            cap_ap     <= 1'b0;
        end else begin
            ld_err     <= 1'b0;
            hour_pulse <= 1'b0;
            case (state)
                RUN: begin
                    if (tick) begin
                        sec        <= sec_inc;
                        min        <= min_inc;
                        h12        <= h12_inc;
                        ap         <= ap_inc;
                        h24        <= to_h24(h12_inc, ap_inc);
                        hour_pulse <= hour_wrap;
                    end
                    if (hold) state <= HOLD;
                end
                HOLD: begin
                    // A pending load wins over releasing hold.
                    if (ld_valid) begin
                        cap_h12 <= ld_h12;
                        cap_min <= ld_min;
                        cap_ap  <= ld_ap;
                        state   <= LOAD;
                    end else if (!hold) begin
                        state <= RUN;
                    end
                end
                LOAD: begin
                    if (load_ok) begin
                        h12 <= cap_h12;
                        min <= cap_min;
                        ap  <= cap_ap;
                        sec <= 6'd0;
                        h24 <= to_h24(cap_h12, cap_ap);
                    end else begin
                        ld_err <= 1'b1;
                    end
                    state <= hold ? HOLD : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_12h_ctrl.sv
// Scoreboard bench for rtc_12h_ctrl: a seconds-of-day reference model queues
// the expected outputs per cycle; a monitor pops and compares after each edge.
module tb_rtc_12h_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       tick = 1'b0;
    logic       hold = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [3:0] ld_h12 = 4'd12;
    logic [5:0] ld_min = 6'd0;
    logic       ld_ap = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] h12;
    logic       ap;
    logic [4:0] h24;
    logic       ld_err;
    logic       hour_pulse;

    rtc_12h_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .hold       (hold),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_h12     (ld_h12),
        .ld_min     (ld_min),
        .ld_ap      (ld_ap),
        .sec        (sec),
        .min        (min),
        .h12        (h12),
        .ap         (ap),
        .h24        (h24),
        .ld_err     (ld_err),
        .hour_pulse (hour_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sec;
        int min;
        int h12;
        int ap;
        int h24;
        int err;
        int hp;
        int rdy;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: time as seconds since midnight, plus the controller mode.
    int t = 0;
    int mode = 0;       // 0 running, 1 holding, 2 applying a load
    int cap_h = 12;
    int cap_m = 0;
    int cap_a = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic void model_step(input int tk, input int hd, input int lv,
                                       input int h, input int m, input int a,
                                       output exp_t e);
        int hr;
        e.err = 0;
        e.hp  = 0;
        case (mode)
            0: begin
                if (tk != 0) begin
                    t = (t + 1) % 86400;
                    e.hp = (t % 3600 == 0) ? 1 : 0;
                end
                if (hd != 0) mode = 1;
            end
            1: begin
                if (lv != 0) begin
                    cap_h = h;
                    cap_m = m;
                    cap_a = a;
                    mode  = 2;
                end else if (hd == 0) begin
                    mode = 0;
                end
            end
            default: begin
                if (cap_h >= 1 && cap_h <= 12 && cap_m <= 59)
                    t = ((cap_h % 12) + 12 * cap_a) * 3600 + cap_m * 60;
                else
                    e.err = 1;
                mode = (hd != 0) ? 1 : 0;
            end
        endcase
        hr    = t / 3600;
        e.h24 = hr;
        e.h12 = (hr % 12 == 0) ? 12 : hr % 12;
        e.ap  = (hr >= 12) ? 1 : 0;
        e.min = (t / 60) % 60;
        e.sec = t % 60;
        e.rdy = (mode == 1) ? 1 : 0;
    endfunction

    // Called at a falling edge: drive inputs, queue the post-edge expectation.
    task automatic step(input int tk, input int hd, input int lv,
                        input int h = 12, input int m = 0, input int a = 0);
        exp_t e;
        tick     = tk[0];
        hold     = hd[0];
        ld_valid = lv[0];
        ld_h12   = h[3:0];
        ld_min   = m[5:0];
        ld_ap    = a[0];
        model_step(tk, hd, lv, h, m, a, e);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sec"}, sec, 0);
        check({tag, "_min"}, min, 0);
        check({tag, "_h12"}, h12, 12);
        check({tag, "_ap"}, ap, 0);
        check({tag, "_h24"}, h24, 0);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_ld_err"}, ld_err, 0);
        check({tag, "_hour_pulse"}, hour_pulse, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("sec", sec, e.sec);
                check("min", min, e.min);
                check("h12", h12, e.h12);
                check("ap", ap, e.ap);
                check("h24", h24, e.h24);
                check("ld_err", ld_err, e.err);
                check("hour_pulse", hour_pulse, e.hp);
                check("ld_ready", ld_ready, e.rdy);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 check_reset("async_rst");
        repeat (3) @(negedge clk);
        check_reset("rst_held");
        t    = 0;
        mode = 0;
        rst_n = 1'b1;
        // First tick lands on the first edge after release; then one full hour.
        repeat (3600) step(1, 0, 0);
        repeat (2) step(0, 0, 0);

        // hold and tick together: tick applied, later ticks dropped.
        step(1, 1, 0);
        repeat (3) step(1, 1, 0);

        // 11:59 AM -> noon.
        step(0, 1, 1, 11, 59, 0);
        step(0, 0, 0);
        repeat (60) step(1, 0, 0);
        step(0, 0, 0);

        // 11:59 PM with hold released in the same cycle as the load, then past 1 AM.
        step(0, 1, 0);
        step(0, 0, 1, 11, 59, 1);
        step(0, 0, 0);
        repeat (3660) step(1, 0, 0);

        // Rejected loads stay in HOLD with time unchanged.
        step(0, 1, 0);
        step(0, 1, 1, 13, 5, 0);
        step(1, 1, 0);
        step(0, 1, 1, 0, 10, 1);
        step(0, 1, 1, 5, 60, 0);
        step(1, 1, 1, 15, 63, 1);
        step(0, 1, 0);
        step(0, 1, 1, 12, 0, 1);
        step(0, 0, 0);
        step(1, 0, 0);

        // Load just before the top of an hour so random ticks can cross it.
        step(0, 1, 0);
        step(0, 1, 1, 6, 59, 1);
        step(0, 0, 0);
        repeat (2000) begin
            step($urandom_range(0, 3) != 0 ? 1 : 0,
                 $urandom_range(0, 15) == 0 ? 1 : 0,
                 $urandom_range(0, 2) == 0 ? 1 : 0,
                 $urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 1));
        end

        // Reset during the LOAD cycle of 07:30 PM discards the load.
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 1, 1, 7, 30, 1);
        rst_n = 1'b0;
        #1 check_reset("rst_in_load");
        t    = 0;
        mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) step(0, 0, 0);
        step(1, 0, 0);

        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
